ipm_distributed_sync_fifo_v2_0: RTL and testbench

Single-clock successor to the distributed-RAM FIFO family. Storage depth is 2^ADDR_WIDTH words of DATA_WIDTH bits, held in a distributed-RAM sub-module (synchronous write, asynchronous read).
- New relative to v1: runtime almost-full/almost-empty thresholds, selectable STANDARD or FWFT read mode, wr_ack/rd_valid handshakes, sticky overflow/underflow flags and synchronous flush.
- Used as the general-purpose intra-clock-domain buffer in datapaths.

---
 rtl/ipm_distributed_fifo_pkg.sv | 23 ++
 rtl/ipm_distributed_sync_fifo_mem_v2_0.sv | 25 ++
 rtl/ipm_distributed_sync_fifo_v2_0.sv | 157 +++++++++++++++
 tb/tb_ipm_distributed_sync_fifo_v2_0.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipm_distributed_fifo_pkg.sv
// Shared constants and helpers for the distributed-RAM FIFO family.
// Read-mode names, a width helper and the even-parity function used when IPM_DIST_FIFO_PARITY_EN is defined.
package ipm_distributed_fifo_pkg;

    localparam string READ_MODE_STANDARD = "STANDARD";
    localparam string READ_MODE_FWFT     = "FWFT";
    localparam int    PARITY_MAX_W       = 256;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    // Callers zero-extend narrower words, which leaves the parity unchanged.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ipm_distributed_sync_fifo_mem_v2_0.sv
// Distributed RAM array for the v2.0 sync FIFO: synchronous write, asynchronous read.
module ipm_distributed_sync_fifo_mem_v2_0 #(
    parameter int ADDR_WIDTH = 4,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    // Storage is deliberately not reset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ipm_distributed_sync_fifo_v2_0.sv
// Single-clock distributed-RAM FIFO with thresholds, STANDARD/FWFT read modes and sticky error flags.
// Optional stored parity is enabled by defining IPM_DIST_FIFO_PARITY_EN.
module ipm_distributed_sync_fifo_v2_0
    import ipm_distributed_fifo_pkg::*;
#(
    parameter int    ADDR_WIDTH = 4,
    parameter int    DATA_WIDTH = 32,
    parameter string READ_MODE  = "STANDARD"
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  wr_ack,
    output logic                  full,
    output logic                  almost_full,
    input  logic [ADDR_WIDTH:0]   almost_full_th,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    input  logic [ADDR_WIDTH:0]   almost_empty_th,
    output logic [ADDR_WIDTH:0]   water_level,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  parity_err
);

    localparam int                DEPTH   = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] ZERO_W  = {(ADDR_WIDTH+1){1'b0}};
    localparam bit                IS_FWFT = (READ_MODE == READ_MODE_FWFT);
`ifdef IPM_DIST_FIFO_PARITY_EN
    localparam int                MEM_W   = DATA_WIDTH + 1;
`else
    localparam int                MEM_W   = DATA_WIDTH;
`endif

    logic [ADDR_WIDTH:0]   wr_ptr_r, rd_ptr_r, level_r, level_nxt_s;
    logic                  full_r, empty_r, af_r, ae_r, settled_r;
    logic                  wr_ack_r, ovf_r, unf_r, std_valid_r, std_perr_r;
    logic [DATA_WIDTH-1:0] std_data_r;
    logic                  wr_go_s, rd_go_s, rd_par_bad_s;
    logic [MEM_W-1:0]      mem_wdata_s, mem_rdata_s;

    // Accepted requests and the level the counter takes on the coming edge.
    always_comb begin
        wr_go_s = wr_en & ~full_r;
        rd_go_s = rd_en & ~empty_r;
        if (flush) begin
            level_nxt_s = ZERO_W;
        end else begin
            level_nxt_s = level_r + {{ADDR_WIDTH{1'b0}}, wr_go_s} - {{ADDR_WIDTH{1'b0}}, rd_go_s};
        end
    end

`ifdef IPM_DIST_FIFO_PARITY_EN
    logic [PARITY_MAX_W-1:0] wr_pad_s, rd_pad_s;

    // Store an even-parity bit with every word and recheck it on the read port.
    always_comb begin
        wr_pad_s = {PARITY_MAX_W{1'b0}};
        rd_pad_s = {PARITY_MAX_W{1'b0}};
        wr_pad_s[DATA_WIDTH-1:0] = wr_data;
        rd_pad_s[DATA_WIDTH-1:0] = mem_rdata_s[DATA_WIDTH-1:0];
        mem_wdata_s  = {even_parity(wr_pad_s), wr_data};
        rd_par_bad_s = even_parity(rd_pad_s) ^ mem_rdata_s[DATA_WIDTH];
    end
`else
    assign mem_wdata_s  = wr_data;
    assign rd_par_bad_s = 1'b0;
`endif

    ipm_distributed_sync_fifo_mem_v2_0 #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (MEM_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_go_s & ~flush),
        .waddr (wr_ptr_r[ADDR_WIDTH-1:0]),
        .wdata (mem_wdata_s),
        .raddr (rd_ptr_r[ADDR_WIDTH-1:0]),
        .rdata (mem_rdata_s)
    );

    // Pointers, level, flags and STANDARD output stage; flags follow the next level so full never lags a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= ZERO_W;
            rd_ptr_r    <= ZERO_W;
            level_r     <= ZERO_W;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            af_r        <= 1'b0;
            ae_r        <= 1'b1;
            settled_r   <= 1'b0;
            wr_ack_r    <= 1'b0;
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
            std_valid_r <= 1'b0;
            std_perr_r  <= 1'b0;
            std_data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            level_r   <= level_nxt_s;
            full_r    <= (level_nxt_s == DEPTH_W);
            empty_r   <= (level_nxt_s == ZERO_W);
            af_r      <= (level_nxt_s >= almost_full_th);
            ae_r      <= (level_nxt_s <= almost_empty_th);
            settled_r <= 1'b1;
            if (flush) begin
                wr_ptr_r    <= ZERO_W;
                rd_ptr_r    <= ZERO_W;
                wr_ack_r    <= 1'b0;
                ovf_r       <= 1'b0;
                unf_r       <= 1'b0;
                std_valid_r <= 1'b0;
                std_perr_r  <= 1'b0;
            end else begin
                wr_ptr_r    <= wr_ptr_r + {{ADDR_WIDTH{1'b0}}, wr_go_s};
                rd_ptr_r    <= rd_ptr_r + {{ADDR_WIDTH{1'b0}}, rd_go_s};
                wr_ack_r    <= wr_go_s;
                ovf_r       <= ovf_r | (wr_en & full_r);
                unf_r       <= unf_r | (rd_en & empty_r);
                std_valid_r <= rd_go_s;
                std_perr_r  <= rd_go_s & rd_par_bad_s;
                if (rd_go_s) begin
                    std_data_r <= mem_rdata_s[DATA_WIDTH-1:0];
                end
            end
        end
    end

    assign wr_ack       = wr_ack_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_empty = ae_r;
    assign water_level  = level_r;
    assign overflow     = ovf_r;
    assign underflow    = unf_r;
    // Until the first edge after reset, almost_full reflects a zero threshold directly.
    assign almost_full  = settled_r ? af_r : (almost_full_th == ZERO_W);

    generate
        if (IS_FWFT) begin : g_fwft
            assign rd_data    = mem_rdata_s[DATA_WIDTH-1:0];
            assign rd_valid   = ~empty_r;
            assign parity_err = ~empty_r & rd_par_bad_s;
        end else begin : g_std
            assign rd_data    = std_data_r;
            assign rd_valid   = std_valid_r;
            assign parity_err = std_perr_r;
        end
    endgenerate

endmodule

// File: tb/tb_ipm_distributed_sync_fifo_v2_0.sv
// Self-checking bench: STANDARD and FWFT instances share stimulus and are checked against a queue model.
module tb_ipm_distributed_sync_fifo_v2_0;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic clk = 1'b0, rst_n = 1'b1, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [DW-1:0] wr_data = 32'd0;
    logic [AW:0]   af_th = 5'd12, ae_th = 5'd3;

    logic s_ack, s_full, s_af, s_valid, s_empty, s_ae, s_ovf, s_unf, s_perr;
    logic f_ack, f_full, f_af, f_valid, f_empty, f_ae, f_ovf, f_unf, f_perr;
    logic [DW-1:0] s_data, f_data;
    logic [AW:0]   s_level, f_level;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_q[$];
    logic          m_ovf = 1'b0, m_unf = 1'b0, m_ack = 1'b0, m_sval = 1'b0;
    logic [DW-1:0] m_sdata = 32'd0;
    logic [AW:0]   m_af_th = 5'd12, m_ae_th = 5'd3;

    wire [8:0] obs_flags = {s_full, s_empty, s_af, s_ae, s_ack, s_ovf, s_unf, s_valid, f_valid};

    always #5 clk = ~clk;

    ipm_distributed_sync_fifo_v2_0 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_MODE("STANDARD")) dut_std (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_data(wr_data), .wr_en(wr_en), .wr_ack(s_ack),
        .full(s_full), .almost_full(s_af), .almost_full_th(af_th), .rd_en(rd_en), .rd_data(s_data),
        .rd_valid(s_valid), .empty(s_empty), .almost_empty(s_ae), .almost_empty_th(ae_th),
        .water_level(s_level), .overflow(s_ovf), .underflow(s_unf), .parity_err(s_perr));

    ipm_distributed_sync_fifo_v2_0 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_MODE("FWFT")) dut_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_data(wr_data), .wr_en(wr_en), .wr_ack(f_ack),
        .full(f_full), .almost_full(f_af), .almost_full_th(af_th), .rd_en(rd_en), .rd_data(f_data),
        .rd_valid(f_valid), .empty(f_empty), .almost_empty(f_ae), .almost_empty_th(ae_th),
        .water_level(f_level), .overflow(f_ovf), .underflow(f_unf), .parity_err(f_perr));

    // Flags the specification implies for the current model contents.
    function automatic logic [8:0] exp_flags();
        int n;
        n = m_q.size();
        return {n == DEPTH, n == 0, n >= int'(m_af_th), n <= int'(m_ae_th),
                m_ack, m_ovf, m_unf, m_sval, n != 0};
    endfunction

    // Apply the current inputs to the model, then let the DUTs take the same edge.
    task automatic tick();
        logic wg, rg;
        m_af_th = af_th;
        m_ae_th = ae_th;
        if (flush) begin
            m_q.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_ack = 1'b0; m_sval = 1'b0;
        end else begin
            wg = wr_en && (m_q.size() < DEPTH);
            rg = rd_en && (m_q.size() > 0);
            m_ovf = m_ovf | (wr_en && !wg);
            m_unf = m_unf | (rd_en && !rg);
            if (rg) m_sdata = m_q.pop_front();
            if (wg) m_q.push_back(wr_data);
            m_ack = wg;
            m_sval = rg;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_ack = 1'b0; m_sval = 1'b0;
        m_sdata = 32'd0;
        m_af_th = af_th;
        m_ae_th = ae_th;
    endtask

    task automatic do_flush();
        flush = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #2;
        checks++; if (obs_flags !== 9'b0_1_0_1_0_0_0_0_0) begin errors++; $display("FAIL reset_flags got %b exp %b", obs_flags, 9'b010100000); end
        checks++; if (s_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", s_level); end
        checks++; if (s_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data got %0h exp 0", s_data); end
        checks++; if ({s_perr, f_perr} !== 2'b00) begin errors++; $display("FAIL reset_parity got %b exp 00", {s_perr, f_perr}); end
        @(posedge clk);
        #5 rst_n = 1'b1;
    endtask

    task automatic test_fill_drain();
        af_th = 5'd16; ae_th = 5'd0;
        do_flush();
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 32'(i);
            tick();
            checks++; if ({s_level, s_full, s_ack} !== {5'(i + 1), i == 15, 1'b1}) begin
                errors++; $display("FAIL fill_%0d got lvl=%0d full=%b ack=%b exp lvl=%0d", i, s_level, s_full, s_ack, i + 1); end
        end
        wr_data = 32'd99;
        tick();
        checks++; if ({s_ack, s_ovf, s_level} !== {1'b0, 1'b1, 5'd16}) begin
            errors++; $display("FAIL write17 got ack=%b ovf=%b lvl=%0d exp ack=0 ovf=1 lvl=16", s_ack, s_ovf, s_level); end
        wr_en = 1'b0; rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (f_data !== 32'(i)) begin errors++; $display("FAIL fwft_head_%0d got %0h exp %0h", i, f_data, i); end
            tick();
            checks++; if ({s_valid, s_data} !== {1'b1, 32'(i)}) begin
                errors++; $display("FAIL drain_%0d got v=%b d=%0h exp v=1 d=%0h", i, s_valid, s_data, i); end
        end
        checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", s_empty); end
        tick();
        rd_en = 1'b0;
        checks++; if ({s_unf, s_valid, s_data} !== {1'b1, 1'b0, 32'd15}) begin
            errors++; $display("FAIL read17 got unf=%b v=%b d=%0h exp unf=1 v=0 d=f", s_unf, s_valid, s_data); end
    endtask

    task automatic test_fwft();
        do_flush();
        wr_data = 32'hA5; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        checks++; if ({f_valid, f_data} !== {1'b1, 32'hA5}) begin
            errors++; $display("FAIL fwft_first_word got v=%b d=%0h exp v=1 d=a5", f_valid, f_data); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if ({f_empty, f_valid, s_data} !== {1'b1, 1'b0, 32'hA5}) begin
            errors++; $display("FAIL fwft_pop got empty=%b v=%b sdata=%0h exp empty=1 v=0 sdata=a5", f_empty, f_valid, s_data); end
    endtask

    task automatic test_thresholds();
        af_th = 5'd12; ae_th = 5'd3;
        do_flush();
        wr_en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            wr_data = $urandom;
            tick();
            if (i == 3 || i == 4) begin
                checks++; if (s_ae !== (i == 3)) begin errors++; $display("FAIL almost_empty_lvl%0d got %b exp %b", i, s_ae, i == 3); end
            end
            if (i == 11 || i == 12) begin
                checks++; if (s_af !== (i == 12)) begin errors++; $display("FAIL almost_full_lvl%0d got %b exp %b", i, s_af, i == 12); end
            end
        end
        wr_en = 1'b0; rd_en = 1'b1;
        tick(); tick();
        rd_en = 1'b0;
        af_th = 5'd8;
        checks++; if ({s_level, s_af} !== {5'd10, 1'b0}) begin errors++; $display("FAIL th_before_edge got lvl=%0d af=%b exp lvl=10 af=0", s_level, s_af); end
        tick();
        checks++; if (s_af !== 1'b1) begin errors++; $display("FAIL th_after_edge got %b exp 1", s_af); end
        af_th = 5'd0; ae_th = 5'd16;
        do_flush();
        checks++; if ({s_af, s_ae} !== 2'b11) begin errors++; $display("FAIL zero_af_th got af=%b ae=%b exp 11", s_af, s_ae); end
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin wr_data = $urandom; tick(); end
        wr_en = 1'b0;
        checks++; if ({s_full, s_ae} !== 2'b11) begin errors++; $display("FAIL ae_th_depth got full=%b ae=%b exp 11", s_full, s_ae); end
        af_th = 5'd12; ae_th = 5'd3;
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] first;
        do_flush();
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = $urandom;
            if (i == 0) first = wr_data;
            tick();
        end
        rd_en = 1'b1; wr_data = $urandom;
        tick();
        checks++; if ({s_level, s_ovf, s_data} !== {5'd15, 1'b1, first}) begin
            errors++; $display("FAIL rw_full got lvl=%0d ovf=%b d=%0h exp lvl=15 ovf=1 d=%0h", s_level, s_ovf, s_data, first); end
        wr_en = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        wr_en = 1'b1; wr_data = 32'hC0FFEE;
        tick();
        checks++; if ({s_level, s_unf, s_valid, f_valid, f_data} !== {5'd1, 1'b1, 1'b0, 1'b1, 32'hC0FFEE}) begin
            errors++; $display("FAIL rw_empty got lvl=%0d unf=%b sv=%b fv=%b fd=%0h exp lvl=1 unf=1 sv=0 fv=1 fd=c0ffee",
                               s_level, s_unf, s_valid, f_valid, f_data); end
        rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin wr_data = $urandom; tick(); end
        rd_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_data = $urandom;
            tick();
            checks++; if ({s_level, s_valid, s_data} !== {5'd5, 1'b1, m_sdata}) begin
                errors++; $display("FAIL rw_wrap_%0d got lvl=%0d v=%b d=%0h exp lvl=5 v=1 d=%0h", i, s_level, s_valid, s_data, m_sdata); end
            checks++; if (f_data !== m_q[0]) begin errors++; $display("FAIL rw_wrap_head_%0d got %0h exp %0h", i, f_data, m_q[0]); end
        end
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_flush();
        do_flush();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0; wr_en = 1'b1;
        for (int i = 0; i < 9; i++) begin wr_data = $urandom; tick(); end
        flush = 1'b1;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        checks++; if ({s_level, f_level} !== {5'd0, 5'd0} || obs_flags !== exp_flags()) begin
            errors++; $display("FAIL flush_lvl9 got lvl=%0d flags=%b exp lvl=0 flags=%b", s_level, obs_flags, exp_flags()); end
        checks++; if (s_data !== m_sdata) begin errors++; $display("FAIL flush_hold_rd_data got %0h exp %0h", s_data, m_sdata); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bit wr_heavy;
            wr_heavy = ((c / 60) % 2) == 0;
            wr_en = ($urandom_range(99) < (wr_heavy ? 80 : 25));
            rd_en = ($urandom_range(99) < (wr_heavy ? 25 : 80));
            flush = ($urandom_range(79) == 0);
            wr_data = $urandom;
            if (c % 37 == 0) begin
                af_th = 5'($urandom_range(16));
                ae_th = 5'($urandom_range(20));
            end
            tick();
            checks++; if (obs_flags !== exp_flags()) begin
                errors++; $display("FAIL rand_flags_%0d got %b exp %b", c, obs_flags, exp_flags()); end
            checks++; if ({s_level, f_level} !== {5'(m_q.size()), 5'(m_q.size())}) begin
                errors++; $display("FAIL rand_level_%0d got %0d/%0d exp %0d", c, s_level, f_level, m_q.size()); end
            checks++; if (s_data !== m_sdata) begin errors++; $display("FAIL rand_sdata_%0d got %0h exp %0h", c, s_data, m_sdata); end
            if (m_q.size() > 0) begin
                checks++; if (f_data !== m_q[0]) begin errors++; $display("FAIL rand_fdata_%0d got %0h exp %0h", c, f_data, m_q[0]); end
            end
            checks++; if ({s_perr, f_perr} !== 2'b00) begin errors++; $display("FAIL rand_parity_%0d got %b exp 00", c, {s_perr, f_perr}); end
        end
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        af_th = 5'd12; ae_th = 5'd3;
    endtask

    task automatic test_parity();
        do_flush();
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin wr_data = $urandom; tick(); end
        wr_en = 1'b0;
`ifdef IPM_DIST_FIFO_PARITY_EN
        dut_std.u_mem.mem[1][3]  = ~dut_std.u_mem.mem[1][3];
        dut_fwft.u_mem.mem[1][3] = ~dut_fwft.u_mem.mem[1][3];
`endif
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic bad;
`ifdef IPM_DIST_FIFO_PARITY_EN
            bad = (i == 1);
`else
            bad = 1'b0;
`endif
            checks++; if (f_perr !== bad) begin errors++; $display("FAIL parity_fwft_%0d got %b exp %b", i, f_perr, bad); end
            tick();
            checks++; if ({s_valid, s_perr} !== {1'b1, bad}) begin
                errors++; $display("FAIL parity_std_%0d got v=%b perr=%b exp v=1 perr=%b", i, s_valid, s_perr, bad); end
        end
        rd_en = 1'b0;
        tick();
        checks++; if (s_perr !== 1'b0) begin errors++; $display("FAIL parity_idle got %b exp 0", s_perr); end
    endtask

    task automatic test_async_reset();
        af_th = 5'd0;
        do_flush();
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin wr_data = $urandom; tick(); end
        rd_en = 1'b1;
        tick();
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (obs_flags !== 9'b0_1_1_1_0_0_0_0_0) begin
            errors++; $display("FAIL async_reset_flags got %b exp %b", obs_flags, 9'b011100000); end
        checks++; if ({s_level, f_level, s_data} !== {5'd0, 5'd0, 32'd0}) begin
            errors++; $display("FAIL async_reset_state got lvl=%0d/%0d d=%0h exp 0/0/0", s_level, f_level, s_data); end
        wr_en = 1'b0; rd_en = 1'b0;
        rst_n = 1'b1;
        af_th = 5'd12;
        tick();
        checks++; if ({s_level, s_empty, s_af} !== {5'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL after_reset got lvl=%0d empty=%b af=%b exp 0 1 0", s_level, s_empty, s_af); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_fwft();
        test_thresholds();
        test_simultaneous();
        test_flush();
        test_random();
        test_parity();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
